fetch_unit: RTL and testbench

- Instruction fetch stage placed directly downstream of the registered 8-bit instruction ROM.
- Owns the program counter and drives the ROM address.
- Captures opcode bytes, and operand bytes where the instruction has one.
- Resolves jumps internally, then issues complete instructions to the decode/execute stage over a valid/ready handshake.

---
 rtl/cpu_defs.sv | 25 ++
 rtl/fetch_len_decode.sv | 27 ++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions for the fetch path and later pipeline stages.
// Holds the two-byte opcode encodings, default datapath widths and the
// fetch FSM state encoding so decode logic and benches can refer to them.
// No ports (package).
package cpu_defs;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;

    // Load immediate: opcode[7:3] matches this prefix, next byte is the data.
    localparam logic [4:0] OP_LOADI_PREFIX = 5'b10110;
    // Jump: next byte is the absolute target address.
    localparam logic [7:0] OP_JUMP         = 8'hC0;
    // Nop: only treated specially when FETCH_NOP_SQUASH_EN is defined.
    localparam logic [7:0] OP_NOP          = 8'hFF;

    typedef enum logic [2:0] {
        FETCH_OP  = 3'd0,
        CAP_OP    = 3'd1,
        FETCH_IMM = 3'd2,
        CAP_IMM   = 3'd3,
        ISSUE     = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_len_decode.sv
// Instruction length decode: classifies an opcode byte.
// Ports:
//   opcode_i       opcode byte to classify
//   is_two_byte_o  opcode is followed by an operand byte (load immediate or jump)
//   is_jump_o      opcode is an unconditional jump
//   is_nop_o       opcode is the nop encoding
module fetch_len_decode
    import cpu_defs::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] opcode_i,
    output logic              is_two_byte_o,
    output logic              is_jump_o,
    output logic              is_nop_o
);

    logic is_loadi;

    always_comb begin
        is_loadi      = (opcode_i[DATA_W-1 -: 5] == OP_LOADI_PREFIX);
        is_jump_o     = (opcode_i == OP_JUMP);
        is_nop_o      = (opcode_i == OP_NOP);
        is_two_byte_o = is_loadi || is_jump_o;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage behind a 1-cycle registered instruction ROM.
// Owns the pc, captures opcode/operand bytes, resolves jumps internally and
// issues complete instructions over a valid/ready handshake.
// Optional build macro: FETCH_NOP_SQUASH_EN drops nop (8'hFF) opcodes in
// CAP_OP instead of issuing them.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rom_addr            ROM address, always equal to pc
//   rom_data            ROM data, valid the cycle after rom_addr
//   instr_valid/ready   issue handshake
//   instr_opcode        issued opcode byte
//   instr_operand       issued immediate byte (0 for single-byte instructions)
//   instr_has_operand   issued opcode was two-byte
//   instr_pc            address of the issued opcode byte
module fetch_unit
    import cpu_defs::*;
#(
    parameter int unsigned          ADDR_W   = DEF_ADDR_W,
    parameter int unsigned          DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_operand,
    output logic              instr_has_operand,
    output logic [ADDR_W-1:0] instr_pc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] op_pc_q, op_pc_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic              has_op_q, has_op_d;

    logic [DATA_W-1:0] dec_opcode;
    logic              is_two_byte;
    logic              is_jump;
    logic              is_nop;

    // In CAP_OP the opcode is still on rom_data; afterwards it lives in op_q.
    assign dec_opcode = (state_q == CAP_OP) ? rom_data : op_q;

    fetch_len_decode #(
        .DATA_W (DATA_W)
    ) u_len_decode (
        .opcode_i      (dec_opcode),
        .is_two_byte_o (is_two_byte),
        .is_jump_o     (is_jump),
        .is_nop_o      (is_nop)
    );

`ifndef FETCH_NOP_SQUASH_EN
    logic unused_is_nop;
    assign unused_is_nop = is_nop;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            op_pc_q   <= '0;
            op_q      <= '0;
            operand_q <= '0;
            has_op_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_pc_q   <= op_pc_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            has_op_q  <= has_op_d;
        end
    end

    // Next-state and datapath capture.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_pc_d   = op_pc_q;
        op_d      = op_q;
        operand_d = operand_q;
        has_op_d  = has_op_q;

        unique case (state_q)
            FETCH_OP: begin
                state_d = CAP_OP;
            end
            CAP_OP: begin
                op_d      = rom_data;
                op_pc_d   = pc_q;
                pc_d      = pc_q + ADDR_W'(1);
                has_op_d  = is_two_byte;
                operand_d = '0;
                state_d   = is_two_byte ? FETCH_IMM : ISSUE;
`ifdef FETCH_NOP_SQUASH_EN
                if (is_nop) begin
                    state_d = FETCH_OP;
                end
`endif
            end
            FETCH_IMM: begin
                state_d = CAP_IMM;
            end
            CAP_IMM: begin
                operand_d = rom_data;
                if (is_jump) begin
                    // Jumps are consumed here and never reach the issue port.
                    pc_d    = ADDR_W'(rom_data);
                    state_d = FETCH_OP;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    state_d = FETCH_OP;
                end
            end
            default: begin
                state_d = FETCH_OP;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        rom_addr          = pc_q;
        instr_valid       = (state_q == ISSUE);
        instr_opcode      = op_q;
        instr_operand     = operand_q;
        instr_has_operand = has_op_q;
        instr_pc          = op_pc_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Two instances: one with the
// default reset pc, one with reset pc 8'hFF for the wrap-around case. Each
// has its own registered ROM model.
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic       rst1;
    logic       ready;
    logic       ready1;

    logic [7:0] a_addr, a_data, a_opcode, a_operand, a_pc;
    logic       a_valid, a_has;
    logic [7:0] b_addr, b_data, b_opcode, b_operand, b_pc;
    logic       b_valid, b_has;

    logic [7:0] rom0 [256];
    logic [7:0] rom1 [256];

    int n_checks;
    int n_fail;

    fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .RESET_PC (8'h00)
    ) dut0 (
        .clk               (clk),
        .rst               (rst),
        .rom_addr          (a_addr),
        .rom_data          (a_data),
        .instr_valid       (a_valid),
        .instr_ready       (ready),
        .instr_opcode      (a_opcode),
        .instr_operand     (a_operand),
        .instr_has_operand (a_has),
        .instr_pc          (a_pc)
    );

    fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .RESET_PC (8'hFF)
    ) dut1 (
        .clk               (clk),
        .rst               (rst1),
        .rom_addr          (b_addr),
        .rom_data          (b_data),
        .instr_valid       (b_valid),
        .instr_ready       (ready1),
        .instr_opcode      (b_opcode),
        .instr_operand     (b_operand),
        .instr_has_operand (b_has),
        .instr_pc          (b_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROMs: data for an address appears one cycle later.
    always @(posedge clk) begin
        a_data <= rom0[a_addr];
        b_data <= rom1[b_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom0();
        for (int i = 0; i < 256; i++) rom0[i] = 8'h00;
    endtask

    // Leaves rst released just after a reset edge: dut0 is in FETCH_OP.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic seen;
    logic bad;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        rst1     = 1'b1;
        ready    = 1'b1;
        ready1   = 1'b1;
        for (int i = 0; i < 256; i++) rom1[i] = 8'h00;
        clear_rom0();

        // Single-byte instruction, reset state.
        rom0[8'h00] = 8'h08;
        do_reset();
        chk("rst_valid", a_valid, 0);
        chk("rst_addr", a_addr, 8'h00);
        chk("rst_opcode", a_opcode, 0);
        tick();
        chk("sb_valid_c1", a_valid, 0);
        tick();
        chk("sb_valid", a_valid, 1);
        chk("sb_opcode", a_opcode, 8'h08);
        chk("sb_has", a_has, 0);
        chk("sb_operand", a_operand, 0);
        chk("sb_pc", a_pc, 8'h00);
        chk("sb_addr", a_addr, 8'h01);
        tick();
        chk("sb_after_valid", a_valid, 0);
        chk("sb_after_addr", a_addr, 8'h01);

        // Load immediate.
        clear_rom0();
        rom0[8'h00] = 8'hB2;
        rom0[8'h01] = 8'h05;
        do_reset();
        tick(); tick(); tick();
        chk("li_valid_c3", a_valid, 0);
        tick();
        chk("li_valid", a_valid, 1);
        chk("li_opcode", a_opcode, 8'hB2);
        chk("li_operand", a_operand, 8'h05);
        chk("li_has", a_has, 1);
        chk("li_pc", a_pc, 8'h00);
        chk("li_addr", a_addr, 8'h02);

        // Two chained jumps (00 -> 09 -> 03), neither issued.
        clear_rom0();
        rom0[8'h00] = 8'hC0;
        rom0[8'h01] = 8'h09;
        rom0[8'h09] = 8'hC0;
        rom0[8'h0A] = 8'h03;
        rom0[8'h03] = 8'h50;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= a_valid;
        end
        chk("jmp1_target", a_addr, 8'h09);
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= a_valid;
        end
        chk("jmp2_target", a_addr, 8'h03);
        tick();
        seen |= a_valid;
        chk("jmp_no_issue", seen, 0);
        tick();
        chk("jmp_next_valid", a_valid, 1);
        chk("jmp_next_opcode", a_opcode, 8'h50);
        chk("jmp_next_pc", a_pc, 8'h03);
        chk("jmp_next_has", a_has, 0);

        // Self-loop jump never issues and stays on addresses 00/01.
        clear_rom0();
        rom0[8'h00] = 8'hC0;
        rom0[8'h01] = 8'h00;
        do_reset();
        seen = 1'b0;
        bad  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen |= a_valid;
            if (a_addr > 8'h01) bad = 1'b1;
        end
        chk("loop_no_issue", seen, 0);
        chk("loop_addr_range", bad, 0);

        // Backpressure: hold ready low for 5 cycles in ISSUE.
        clear_rom0();
        rom0[8'h00] = 8'hA0;
        rom0[8'h01] = 8'h33;
        ready = 1'b0;
        do_reset();
        tick(); tick();
        chk("bp_valid0", a_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", a_valid, 1);
            chk("bp_opcode", a_opcode, 8'hA0);
            chk("bp_pc", a_pc, 8'h00);
            chk("bp_addr", a_addr, 8'h01);
        end
        ready = 1'b1;
        tick();
        chk("bp_acc_valid", a_valid, 0);
        chk("bp_acc_addr", a_addr, 8'h01);
        tick(); tick();
        chk("bp_next_valid", a_valid, 1);
        chk("bp_next_opcode", a_opcode, 8'h33);
        chk("bp_next_pc", a_pc, 8'h01);
        chk("bp_next_addr", a_addr, 8'h02);

        // Reset during CAP_IMM discards the in-flight load immediate.
        clear_rom0();
        rom0[8'h00] = 8'hB0;
        rom0[8'h01] = 8'h44;
        do_reset();
        tick(); tick(); tick();
        chk("mid_opcode", a_opcode, 8'hB0);
        chk("mid_valid", a_valid, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", a_valid, 0);
        chk("mid_rst_opcode", a_opcode, 0);
        chk("mid_rst_operand", a_operand, 0);
        chk("mid_rst_has", a_has, 0);
        chk("mid_rst_pc", a_pc, 0);
        chk("mid_rst_addr", a_addr, 8'h00);
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mid_re_valid", a_valid, 1);
        chk("mid_re_operand", a_operand, 8'h44);
        chk("mid_re_pc", a_pc, 8'h00);

        // Nop handling at 05 (reached via a jump).
        clear_rom0();
        rom0[8'h00] = 8'hC0;
        rom0[8'h01] = 8'h05;
        rom0[8'h05] = 8'hFF;
        rom0[8'h06] = 8'hB1;
        rom0[8'h07] = 8'h02;
        do_reset();
`ifdef FETCH_NOP_SQUASH_EN
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            seen |= a_valid;
        end
        chk("nop_squashed", seen, 0);
        tick();
`else
        for (int i = 0; i < 6; i++) tick();
        chk("nop_valid", a_valid, 1);
        chk("nop_opcode", a_opcode, 8'hFF);
        chk("nop_pc", a_pc, 8'h05);
        chk("nop_has", a_has, 0);
        for (int i = 0; i < 5; i++) tick();
`endif
        chk("post_nop_valid", a_valid, 1);
        chk("post_nop_opcode", a_opcode, 8'hB1);
        chk("post_nop_operand", a_operand, 8'h02);
        chk("post_nop_pc", a_pc, 8'h06);

        // Wrap-around: opcode at FF, operand at 00.
        rom1[8'hFF] = 8'hB1;
        rom1[8'h00] = 8'h07;
        chk("wrap_rst_addr", b_addr, 8'hFF);
        chk("wrap_rst_valid", b_valid, 0);
        rst1 = 1'b0;
        tick(); tick(); tick(); tick();
        chk("wrap_valid", b_valid, 1);
        chk("wrap_opcode", b_opcode, 8'hB1);
        chk("wrap_operand", b_operand, 8'h07);
        chk("wrap_has", b_has, 1);
        chk("wrap_pc", b_pc, 8'hFF);
        chk("wrap_addr", b_addr, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
